// File: rtl/nvrcfg_pkg.sv
// Shared types and helpers for the NVR configuration loader.
package nvrcfg_pkg;

  // Loader FSM states, used for the debug view of the state register.
  typedef enum logic [2:0] {
    LD_IDLE   = 3'd0,
    LD_SKIP   = 3'd1,
    LD_REQ    = 3'd2,
    LD_COMMIT = 3'd3,
    LD_FIN    = 3'd4
  } ldst_e;

  // Raw state encodings carried by the state flop.
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SKIP   = 3'd1;
  localparam logic [2:0] ST_REQ    = 3'd2;
  localparam logic [2:0] ST_COMMIT = 3'd3;
  localparam logic [2:0] ST_FIN    = 3'd4;

  // Reference row width and row type for code that handles one default row.
  localparam int unsigned RRAW = 256;
  typedef logic [RRAW-1:0] nvrdat_t;

  // Number of read beats that make up one configuration row.
  function automatic int unsigned beats_per_row(input int unsigned rw, input int unsigned bw);
    return rw / bw;
  endfunction

endpackage

// File: rtl/nvrcfg_rowasm.sv
// Row assembler: collects the beats of one row, tracks whether any beat was
// bad and flags an erased (all-ones) row. Cleared when a new row starts.
module nvrcfg_rowasm #(
  parameter int unsigned RW  = 256,
  parameter int unsigned BW  = 64,
  parameter int unsigned BIW = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  input  logic           beat_we,
  input  logic [BIW-1:0] beat_idx,
  input  logic [BW-1:0]  beat_data,
  input  logic           beat_bad,
  output logic [RW-1:0]  row_buf,
  output logic           row_bad,
  output logic           all_ones
);

  logic [RW-1:0] rbuf_q, rbuf_d;
  logic          bad_q, bad_d;
  logic [31:0]   slot_off;

  assign slot_off = 32'(beat_idx) * 32'(BW);

  // Next buffer contents and sticky bad flag.
  always_comb begin
    rbuf_d = rbuf_q;
    bad_d  = bad_q | beat_bad;
    if (clr) begin
      rbuf_d = '0;
      bad_d  = 1'b0;
    end else if (beat_we) begin
      rbuf_d[slot_off +: BW] = beat_data;
    end
  end

  // Buffer and flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rbuf_q <= '0;
      bad_q  <= 1'b0;
    end else begin
      rbuf_q <= rbuf_d;
      bad_q  <= bad_d;
    end
  end

  assign row_buf  = rbuf_q;
  assign row_bad  = bad_q;
  assign all_ones = &rbuf_q;

endmodule

// File: rtl/nvrcfg_loader.sv
// Boot-time NVR configuration loader with a defaulting shadow store.
//
// Read handshake: rd_req is raised with a stable rd_addr and held until the
// cycle rd_ack is seen high (rd_rdata/rd_err valid in that same cycle); it
// then drops for at least one cycle. rd_ack while rd_req is low is ignored.
// A beat with no rd_ack within TOCYC rd_req cycles is abandoned as bad.
module nvrcfg_loader
  import nvrcfg_pkg::*;
#(
  parameter int unsigned         ROWS    = 32,
  parameter int unsigned         RW      = 256,
  parameter int unsigned         BW      = 64,
  parameter int unsigned         AW      = 22,
  parameter logic [AW-1:0]       BASE    = '0,
  parameter int unsigned         TOCYC   = 64,
  parameter logic [ROWS-1:0]     ROWMASK = '1,
  parameter logic [ROWS*RW-1:0]  DEFROWS = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 reload,
  output logic                 rd_req,
  output logic [AW-1:0]        rd_addr,
  input  logic                 rd_ack,
  input  logic [BW-1:0]        rd_rdata,
  input  logic                 rd_err,
  output logic [ROWS*RW-1:0]   cfg_q,
  output logic [ROWS-1:0]      row_dflt,
  output logic                 busy,
  output logic                 done,
  output ldst_e                dbg_state
);

  localparam int unsigned NB  = beats_per_row(RW, BW);
  localparam int unsigned BIW = (NB > 1) ? $clog2(NB) : 1;
  localparam int unsigned RIW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned TW  = $clog2(TOCYC);

  logic [2:0]          state_q, state_d;
  logic [RIW-1:0]      row_q, row_d;
  logic [BIW-1:0]      beat_q, beat_d;
  logic [TW-1:0]       tocnt_q, tocnt_d;
  logic                pend_q, pend_d;
  logic                rd_req_q, rd_req_d;
  logic [AW-1:0]       rd_addr_q, rd_addr_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [ROWS*RW-1:0]  shadow_q, shadow_d;
  logic [ROWS-1:0]     dflt_q, dflt_d;

  logic                asm_clr, asm_we, asm_bad;
  logic [RW-1:0]       asm_buf;
  logic                asm_row_bad, asm_all_ones;
  logic [31:0]         row_off;

  assign row_off = 32'(row_q) * 32'(RW);

  // Byte address of a beat, wrapped to the address width.
  function automatic logic [AW-1:0] beat_addr(input logic [RIW-1:0] r, input logic [BIW-1:0] b);
    logic [63:0] a;
    a = 64'(BASE) + 64'(r) * 64'(RW / 8) + 64'(b) * 64'(BW / 8);
    return a[AW-1:0];
  endfunction

  nvrcfg_rowasm #(.RW(RW), .BW(BW), .BIW(BIW)) u_rowasm (
    .clk       (clk),
    .rst       (reset),
    .clr       (asm_clr),
    .beat_we   (asm_we),
    .beat_idx  (beat_q),
    .beat_data (rd_rdata),
    .beat_bad  (asm_bad),
    .row_buf   (asm_buf),
    .row_bad   (asm_row_bad),
    .all_ones  (asm_all_ones)
  );

  // Load sequencing: row walk, beat requests with timeout, row commit.
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    beat_d    = beat_q;
    tocnt_d   = tocnt_q;
    pend_d    = pend_q;
    rd_req_d  = rd_req_q;
    rd_addr_d = rd_addr_q;
    busy_d    = busy_q;
    done_d    = done_q;
    shadow_d  = shadow_q;
    dflt_d    = dflt_q;
    asm_clr   = 1'b0;
    asm_we    = 1'b0;
    asm_bad   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pend_q || reload) begin
          pend_d  = 1'b0;
          done_d  = 1'b0;
          busy_d  = 1'b1;
          row_d   = '0;
          state_d = ST_SKIP;
        end
      end
      ST_SKIP: begin
        if (!ROWMASK[row_q]) begin
          // Masked rows keep whatever default the shadow already holds.
          dflt_d[row_q] = 1'b1;
          if (row_q == RIW'(ROWS - 1)) state_d = ST_FIN;
          else row_d = row_q + RIW'(1);
        end else begin
          beat_d  = '0;
          tocnt_d = '0;
          asm_clr = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (!rd_req_q) begin
          rd_req_d  = 1'b1;
          rd_addr_d = beat_addr(row_q, beat_q);
          tocnt_d   = '0;
        end else begin
          if (rd_ack) begin
            asm_we  = 1'b1;
            asm_bad = rd_err;
          end else if (tocnt_q == TW'(TOCYC - 1)) begin
            asm_bad = 1'b1;
          end else begin
            tocnt_d = tocnt_q + TW'(1);
          end
          if (rd_ack || (tocnt_q == TW'(TOCYC - 1))) begin
            rd_req_d = 1'b0;
            tocnt_d  = '0;
            if (beat_q == BIW'(NB - 1)) state_d = ST_COMMIT;
            else beat_d = beat_q + BIW'(1);
          end
        end
      end
      ST_COMMIT: begin
        if (asm_row_bad || asm_all_ones) begin
          shadow_d[row_off +: RW] = DEFROWS[row_off +: RW];
          dflt_d[row_q]           = 1'b1;
        end else begin
          shadow_d[row_off +: RW] = asm_buf;
          dflt_d[row_q]           = 1'b0;
        end
        if (row_q == RIW'(ROWS - 1)) begin
          state_d = ST_FIN;
        end else begin
          row_d   = row_q + RIW'(1);
          state_d = ST_SKIP;
        end
      end
      ST_FIN: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counters, read port and shadow registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      row_q     <= '0;
      beat_q    <= '0;
      tocnt_q   <= '0;
      pend_q    <= 1'b1;
      rd_req_q  <= 1'b0;
      rd_addr_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      shadow_q  <= DEFROWS;
      dflt_q    <= '1;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      beat_q    <= beat_d;
      tocnt_q   <= tocnt_d;
      pend_q    <= pend_d;
      rd_req_q  <= rd_req_d;
      rd_addr_q <= rd_addr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      shadow_q  <= shadow_d;
      dflt_q    <= dflt_d;
    end
  end

  assign rd_req    = rd_req_q;
  assign rd_addr   = rd_addr_q;
  assign cfg_q     = shadow_q;
  assign row_dflt  = dflt_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = ldst_e'(state_q);

endmodule
